id_ex_issue_ctrl: RTL and testbench

- Issue controller sequencing the ID/EX pipe register of the vector processor.
- Tracks pending writes to the 16 scalar and 16 vector registers in a scoreboard, and tracks occupancy of the multi-cycle vector execute unit.
- Each cycle it decides whether the decoded instruction issues into ID/EX, or whether decode stalls and a bubble (all control fields zero) is loaded instead.

---
 rtl/idex_ctrl_pkg.sv | 18 +
 rtl/idex_scoreboard.sv | 39 +++
 rtl/id_ex_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_id_ex_issue_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/idex_ctrl_pkg.sv
// Shared types and sizes for the ID/EX issue controller.
// Register index width, register count, register-file type and vector FSM states.
package idex_ctrl_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;

    typedef enum logic {
        RT_SCALAR = 1'b0,
        RT_VECTOR = 1'b1
    } reg_type_t;

    typedef enum logic {
        RUN,
        VBUSY
    } vec_state_t;

endpackage

// File: rtl/idex_scoreboard.sv
// Pending-write scoreboard for the scalar and vector register files.
// Ports: clk, rst, clear (writeback) and set (issue) requests,
//        pending (registered bits), eff_pend (pending with this cycle's clear applied).
module idex_scoreboard
    import idex_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_en,
    input  reg_type_t             clr_type,
    input  logic [REG_IDX_W-1:0]  clr_idx,
    input  logic                  set_en,
    input  reg_type_t             set_type,
    input  logic [REG_IDX_W-1:0]  set_idx,
    output logic [2*NUM_REGS-1:0] pending,
    output logic [2*NUM_REGS-1:0] eff_pend
);

    logic [2*NUM_REGS-1:0] clr_mask;
    logic [2*NUM_REGS-1:0] set_mask;

    // Bit index is {type, idx}: scalar in [15:0], vector in [31:16].
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[{clr_type, clr_idx}] = 1'b1;
        if (set_en) set_mask[{set_type, set_idx}] = 1'b1;
    end

    // Write-first register file: a retiring write resolves the hazard now.
    assign eff_pend = pending & ~clr_mask;

    // Set is applied after clear so a new producer keeps the bit.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= eff_pend | set_mask;
    end

endmodule

// File: rtl/id_ex_issue_ctrl.sv
// ID/EX issue controller: hazard detection, stall/bubble control, vector unit occupancy.
// Ports: decode operands/dest, writeback retire, flush -> issue, stall_id, bubble_ex,
//        vec_busy, sb_pending. IDEX_PERF_CNT_EN adds stall_cycles and flush_cycles.
module id_ex_issue_ctrl
    import idex_ctrl_pkg::*;
#(
    parameter int VEC_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_r1_use,
    input  logic [REG_IDX_W-1:0] id_r1_idx,
    input  logic                 id_r1_type,
    input  logic                 id_r2_use,
    input  logic [REG_IDX_W-1:0] id_r2_idx,
    input  logic                 id_r2_type,
    input  logic                 id_wb_en,
    input  logic [REG_IDX_W-1:0] id_dest,
    input  logic                 id_dest_type,
    input  logic                 id_is_vec_op,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 wb_dest_type,
    input  logic                 flush,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_cycles,
`endif
    output logic                 issue,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic                 vec_busy,
    output logic [31:0]          sb_pending
);

    localparam logic [3:0] VCNT_LOAD = 4'(VEC_LAT - 1);
    localparam bit         MULTI     = (VEC_LAT > 1);

    vec_state_t  state, state_n;
    logic [3:0]  vcnt, vcnt_n;
    logic [31:0] eff_pend;
    logic        raw, waw, st_haz, hazard, live, vec_issue;

    idex_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (wb_valid),
        .clr_type (reg_type_t'(wb_dest_type)),
        .clr_idx  (wb_dest),
        .set_en   (issue & id_wb_en),
        .set_type (reg_type_t'(id_dest_type)),
        .set_idx  (id_dest),
        .pending  (sb_pending),
        .eff_pend (eff_pend)
    );

    assign raw = (id_r1_use & eff_pend[{id_r1_type, id_r1_idx}])
               | (id_r2_use & eff_pend[{id_r2_type, id_r2_idx}]);
    assign waw = id_wb_en & eff_pend[{id_dest_type, id_dest}];
    // On the last busy cycle the unit frees at this edge: allow back-to-back.
    assign st_haz = id_is_vec_op & (state == VBUSY) & (vcnt > 4'd1);
    assign hazard = raw | waw | st_haz;

    // Flush and reset both win over any hazard.
    assign live      = id_valid & ~flush & ~rst;
    assign issue     = live & ~hazard;
    assign stall_id  = live & hazard;
    assign bubble_ex = ~issue;
    assign vec_issue = issue & id_is_vec_op;
    assign vec_busy  = (state == VBUSY);

    always_comb begin
        state_n = state;
        vcnt_n  = vcnt;
        unique case (state)
            RUN: begin
                if (vec_issue && MULTI) begin
                    state_n = VBUSY;
                    vcnt_n  = VCNT_LOAD;
                end
            end
            VBUSY: begin
                if (vec_issue) begin
                    vcnt_n = VCNT_LOAD;
                end else if (vcnt <= 4'd1) begin
                    state_n = RUN;
                    vcnt_n  = 4'd0;
                end else begin
                    vcnt_n = vcnt - 4'd1;
                end
            end
            default: begin
                state_n = RUN;
                vcnt_n  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            vcnt  <= 4'd0;
        end else begin
            state <= state_n;
            vcnt  <= vcnt_n;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_id)          stall_cycles <= stall_cycles + 32'd1;
            if (flush && id_valid) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// Randomized self-checking bench for id_ex_issue_ctrl against a cycle-level model.
// Model keeps pending bits per register and the cycle of the last vector issue.
module tb_id_ex_issue_ctrl;

    localparam int VEC_LAT = 4;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       r1_use;
        logic [3:0] r1_idx;
        logic       r1_type;
        logic       r2_use;
        logic [3:0] r2_idx;
        logic       r2_type;
        logic       wb_en;
        logic [3:0] dest;
        logic       dest_type;
        logic       is_vec;
        logic       wb_valid;
        logic [3:0] wb_dest;
        logic       wb_type;
        logic       flush;
    } stim_t;

    logic        clk = 1'b0;
    stim_t       s;
    logic        issue, stall_id, bubble_ex, vec_busy;
    logic [31:0] sb_pending;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    bit          pend [2][16];
    int          last_vec = -1000;
    int          cyc_n    = 0;
    logic [31:0] m_stall  = 0;
    logic [31:0] m_flush  = 0;

    always #5 clk = ~clk;

    id_ex_issue_ctrl #(.VEC_LAT(VEC_LAT)) dut (
        .clk          (clk),
        .rst          (s.rst),
        .id_valid     (s.valid),
        .id_r1_use    (s.r1_use),
        .id_r1_idx    (s.r1_idx),
        .id_r1_type   (s.r1_type),
        .id_r2_use    (s.r2_use),
        .id_r2_idx    (s.r2_idx),
        .id_r2_type   (s.r2_type),
        .id_wb_en     (s.wb_en),
        .id_dest      (s.dest),
        .id_dest_type (s.dest_type),
        .id_is_vec_op (s.is_vec),
        .wb_valid     (s.wb_valid),
        .wb_dest      (s.wb_dest),
        .wb_dest_type (s.wb_type),
        .flush        (s.flush),
`ifdef IDEX_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
`endif
        .issue        (issue),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .vec_busy     (vec_busy),
        .sb_pending   (sb_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic bit eff(input logic t, input logic [3:0] i);
        bit cleared;
        cleared = s.wb_valid && (s.wb_type == t) && (s.wb_dest == i);
        return pend[t][i] && !cleared;
    endfunction

    task automatic cyc();
        bit raw, waw, st, e_issue, e_stall, e_busy;
        int d;
        logic [31:0] e_sb;
        @(negedge clk);
        d   = cyc_n - last_vec;
        raw = (s.r1_use && eff(s.r1_type, s.r1_idx))
           || (s.r2_use && eff(s.r2_type, s.r2_idx));
        waw = s.wb_en && eff(s.dest_type, s.dest);
        st  = s.is_vec && (d <= VEC_LAT - 2);
        e_issue = !s.rst && s.valid && !s.flush && !(raw || waw || st);
        e_stall = !s.rst && s.valid && !s.flush && (raw || waw || st);
        e_busy  = (d >= 1) && (d <= VEC_LAT - 1);
        for (int i = 0; i < 16; i++) begin
            e_sb[i]      = pend[0][i];
            e_sb[16 + i] = pend[1][i];
        end
        chk("issue", 32'(issue), 32'(e_issue));
        chk("stall_id", 32'(stall_id), 32'(e_stall));
        chk("bubble_ex", 32'(bubble_ex), 32'(!e_issue));
        chk("vec_busy", 32'(vec_busy), 32'(e_busy));
        chk("sb_pending", sb_pending, e_sb);
`ifdef IDEX_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_cycles", flush_cycles, m_flush);
`endif
        if (s.rst) begin
            for (int t = 0; t < 2; t++)
                for (int i = 0; i < 16; i++) pend[t][i] = 1'b0;
            last_vec = -1000;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if (s.wb_valid) pend[s.wb_type][s.wb_dest] = 1'b0;
            if (e_issue && s.wb_en) pend[s.dest_type][s.dest] = 1'b1;
            if (e_issue && s.is_vec) last_vec = cyc_n;
            if (e_stall) m_stall = m_stall + 1;
            if (s.flush && s.valid) m_flush = m_flush + 1;
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic op_wr(input logic t, input logic [3:0] i, input logic v);
        s = '0;
        s.valid = 1'b1;
        s.wb_en = 1'b1;
        s.dest = i;
        s.dest_type = t;
        s.is_vec = v;
    endtask

    task automatic op_rd(input logic t, input logic [3:0] i);
        s = '0;
        s.valid = 1'b1;
        s.r1_use = 1'b1;
        s.r1_idx = i;
        s.r1_type = t;
    endtask

    initial begin
        s = '0;
        s.rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s = '0;
        cyc();
        // RAW on s3 until writeback clears it
        op_wr(0, 3, 0); cyc();
        op_rd(0, 3); cyc();
        cyc();
        s.wb_valid = 1'b1; s.wb_dest = 3; s.wb_type = 0; cyc();
        s = '0; cyc();
        // vector v5 pending does not block scalar s5
        op_wr(1, 5, 0); cyc();
        op_rd(0, 5); cyc();
        // structural: back-to-back vector ops
        s = '0; s.valid = 1; s.is_vec = 1; cyc();
        repeat (4) cyc();
        s = '0; repeat (4) cyc();
        // same-cycle clear and set of s7
        op_wr(0, 7, 0); cyc();
        op_wr(0, 7, 0);
        s.wb_valid = 1; s.wb_dest = 7; s.wb_type = 0; cyc();
        // flush beats a RAW hazard
        op_rd(0, 7); s.flush = 1; cyc();
        s = '0; cyc();
        // reset while busy with s3 and v0 pending
        s.rst = 1; cyc();
        op_wr(0, 3, 0); cyc();
        op_wr(1, 0, 1); cyc();
        s = '0; cyc();
        op_rd(0, 3); cyc();
        s = '0; s.rst = 1; cyc();
        s = '0; cyc();

        for (int n = 0; n < 600; n++) begin
            s = '0;
            s.rst       = ($urandom_range(0, 63) == 0);
            s.valid     = ($urandom_range(0, 3) != 0);
            s.r1_use    = $urandom_range(0, 1);
            s.r1_idx    = 4'($urandom_range(0, 3));
            s.r1_type   = $urandom_range(0, 1);
            s.r2_use    = $urandom_range(0, 1);
            s.r2_idx    = 4'($urandom_range(0, 3));
            s.r2_type   = $urandom_range(0, 1);
            s.wb_en     = $urandom_range(0, 1);
            s.dest      = 4'($urandom_range(0, 3));
            s.dest_type = $urandom_range(0, 1);
            s.is_vec    = $urandom_range(0, 1);
            s.wb_valid  = $urandom_range(0, 1);
            s.wb_dest   = 4'($urandom_range(0, 3));
            s.wb_type   = $urandom_range(0, 1);
            s.flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
